// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the direct-mapped data cache.
package cache_pkg;

  localparam int INDEX_W = 6;
  localparam int OFF_W   = 2;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int LINES   = 2 ** INDEX_W;
  localparam int WORDS   = 2 ** OFF_W;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[2+OFF_W +: INDEX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[2 +: OFF_W];
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Line data storage: LINES x WORDS words, asynchronous read, one synchronous write per cycle.
module cache_data_ram
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_line,
  input  logic [OFF_W-1:0]   rd_word,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_line,
  input  logic [OFF_W-1:0]   wr_word,
  input  logic [31:0]        wr_data
);

  logic [31:0] mem [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_line][wr_word] <= wr_data;
  end

  assign rd_data = mem[rd_line][rd_word];

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped write-back/write-allocate data cache: zero-stall hits, writeback-then-refill on a miss.
module dcache_dm_wb
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cache_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_t             state_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [TAG_W-1:0]   miss_tag_q;
  logic [INDEX_W-1:0] miss_index_q;

  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] cpu_index;
  logic [OFF_W-1:0]   cpu_word;
  logic               req, hit, last_word, idle;
  logic [INDEX_W-1:0] ram_rd_line, ram_wr_line;
  logic [OFF_W-1:0]   ram_rd_word, ram_wr_word;
  logic [31:0]        ram_rd_data, ram_wr_data;
  logic               ram_wr_en;

  assign cpu_tag   = addr_tag(cpu_addr);
  assign cpu_index = addr_index(cpu_addr);
  assign cpu_word  = addr_word(cpu_addr);
  assign req       = cpu_re | cpu_we;
  assign hit       = req & valid_q[cpu_index] & (tag_q[cpu_index] == cpu_tag);
  assign last_word = &cnt_q;
  assign idle      = (state_q == IDLE);

  // The single RAM port serves the CPU when idle and the latched miss line otherwise.
  assign ram_rd_line = idle ? cpu_index : miss_index_q;
  assign ram_rd_word = idle ? cpu_word  : cnt_q;
  assign ram_wr_line = idle ? cpu_index : miss_index_q;
  assign ram_wr_word = idle ? cpu_word  : cnt_q;
  assign ram_wr_data = idle ? cpu_wdata : mem_rdata;
  assign ram_wr_en   = (idle & cpu_we & hit) | ((state_q == REFILL) & mem_ack);

  cache_data_ram u_data_ram (
    .clk     (clk),
    .rd_line (ram_rd_line),
    .rd_word (ram_rd_word),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_line (ram_wr_line),
    .wr_word (ram_wr_word),
    .wr_data (ram_wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (cpu_we) dirty_q[cpu_index] <= 1'b1;
          end else if (req) begin
            miss_tag_q   <= cpu_tag;
            miss_index_q <= cpu_index;
            cnt_q        <= '0;
            state_q      <= (valid_q[cpu_index] & dirty_q[cpu_index]) ? WB : REFILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              dirty_q[miss_index_q] <= 1'b0;
              state_q               <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              valid_q[miss_index_q] <= 1'b1;
              dirty_q[miss_index_q] <= 1'b0;
              state_q               <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tags are only meaningful behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && mem_ack && last_word) tag_q[miss_index_q] <= miss_tag_q;
  end

  // Outputs are forced to their idle values while reset is held, even with a CPU request pending.
  always_comb begin
    cache_stall = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (hit) cpu_rdata = ram_rd_data;
          else if (req) cache_stall = 1'b1;
        end
        WB: begin
          cache_stall = 1'b1;
          mem_req     = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = {tag_q[miss_index_q], miss_index_q, cnt_q, 2'b00};
          mem_wdata   = ram_rd_data;
        end
        REFILL: begin
          cache_stall = 1'b1;
          mem_req     = 1'b1;
          mem_addr    = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Bench for dcache_dm_wb: directed vector table, reset-mid-refill sequence, then random traffic
// checked against a flat architectural memory plus a per-index residency model.
module tb_dcache_dm_wb;

  logic        clk;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cache_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  // Main memory as seen by the cache, and memory as the CPU should see it.
  logic [31:0] backing [16384];
  logic [31:0] arch    [16384];
  logic        m_valid [64];
  logic        m_dirty [64];
  logic [21:0] m_tag   [64];

  dcache_dm_wb dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_re      (cpu_re),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cache_stall (cache_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    for (int i = 0; i < 16384; i++) arch[i] = backing[i];
  endtask

  // One CPU access, acting as memory slave with random ack gaps of 0..gapmax cycles.
  task automatic apply_stimulus(input logic re, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gapmax,
                                output int stalls, output logic [31:0] rdata_seen);
    int idx, gap, exp_stall, wb_k, rd_k, acks, n_words, guard;
    logic req, hit_exp, miss, dirty_exp, waiting;
    logic [31:0] held_addr, held_wdata, exp_rdata;
    idx       = int'(addr[9:4]);
    req       = re | we;
    hit_exp   = req && m_valid[idx] && (m_tag[idx] == addr[31:10]);
    miss      = req && !hit_exp;
    dirty_exp = miss && m_valid[idx] && m_dirty[idx];
    n_words   = dirty_exp ? 8 : 4;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 1'b0;
    #1;
    check_output("stall_on_request", 32'(cache_stall), 32'(miss));
    stalls = 0; exp_stall = 0; wb_k = 0; rd_k = 0; acks = 0; guard = 0; waiting = 1'b0;
    held_addr = '0; held_wdata = '0; gap = 0;
    if (miss) begin
      gap = int'($urandom_range(gapmax, 0));
      exp_stall = 2 + gap;
    end
    while (cache_stall && guard < 400) begin
      stalls++;
      guard++;
      if (mem_req) begin
        if (waiting) begin
          check_output("addr_held", mem_addr, held_addr);
          if (mem_we) check_output("wdata_held", mem_wdata, held_wdata);
        end
        waiting = 1'b1; held_addr = mem_addr; held_wdata = mem_wdata;
        if (gap == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            check_output("wb_addr", mem_addr, {m_tag[idx], addr[9:4], 2'(wb_k), 2'b00});
            check_output("wb_data", mem_wdata, arch[mem_addr[15:2]]);
            backing[mem_addr[15:2]] = mem_wdata;
            wb_k++;
          end else begin
            check_output("refill_addr", mem_addr, {addr[31:10], addr[9:4], 2'(rd_k), 2'b00});
            mem_rdata = backing[mem_addr[15:2]];
            rd_k++;
          end
          waiting = 1'b0;
          acks++;
          if (acks < n_words) begin
            gap = int'($urandom_range(gapmax, 0));
            exp_stall += gap + 1;
          end
        end else begin
          gap--;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
    end
    check_output("stall_bounded", 32'(guard < 400), 32'd1);
    check_output("stall_cycles", 32'(stalls), 32'(exp_stall));
    if (miss) begin
      check_output("wb_words", 32'(wb_k), dirty_exp ? 32'd4 : 32'd0);
      check_output("refill_words", 32'(rd_k), 32'd4);
    end
    exp_rdata = req ? arch[addr[15:2]] : 32'd0;
    check_output("cpu_rdata", cpu_rdata, exp_rdata);
    rdata_seen = cpu_rdata;
    if (miss) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = addr[31:10];
    end
    if (we) begin
      arch[addr[15:2]] = wdata;
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gapmax;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  int          st;
  logic [31:0] rd;
  logic [21:0] tag_pick [5];
  int          kind;
  logic [31:0] a;

  initial begin
    rst = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 16384; i++) backing[i] = 32'h5000_0000 | 32'(i);
    for (int i = 0; i < 4; i++) begin
      backing[32'h40 + i]   = 32'hA0 + 32'(i);
      backing[32'h1040 + i] = 32'hB0 + 32'(i);
    end
    model_reset();

    #1;
    check_output("reset_mem_req", 32'(mem_req), 32'd0);
    check_output("reset_mem_we", 32'(mem_we), 32'd0);
    check_output("reset_mem_addr", mem_addr, 32'd0);
    check_output("reset_mem_wdata", mem_wdata, 32'd0);
    check_output("reset_stall", 32'(cache_stall), 32'd0);
    check_output("reset_rdata", cpu_rdata, 32'd0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{re: 1'b1, we: 1'b0, addr: 32'h0000_0104, wdata: 32'h0,         gapmax: 0, exp_stall: 5, exp_rdata: 32'hA1};
    vecs[1] = '{re: 1'b0, we: 1'b1, addr: 32'h0000_0104, wdata: 32'hDEADBEEF, gapmax: 0, exp_stall: 0, exp_rdata: 32'hA1};
    vecs[2] = '{re: 1'b1, we: 1'b0, addr: 32'h0000_0104, wdata: 32'h0,         gapmax: 0, exp_stall: 0, exp_rdata: 32'hDEADBEEF};
    vecs[3] = '{re: 1'b1, we: 1'b0, addr: 32'h0000_4104, wdata: 32'h0,         gapmax: 0, exp_stall: 9, exp_rdata: 32'hB1};
    vecs[4] = '{re: 1'b1, we: 1'b1, addr: 32'h0000_4104, wdata: 32'h1234,      gapmax: 0, exp_stall: 0, exp_rdata: 32'hB1};
    vecs[5] = '{re: 1'b1, we: 1'b0, addr: 32'h0000_4104, wdata: 32'h0,         gapmax: 0, exp_stall: 0, exp_rdata: 32'h1234};
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].re, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].gapmax, st, rd);
      check_output($sformatf("vec%0d_stall", v), 32'(st), 32'(vecs[v].exp_stall));
      check_output($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
    end
    check_output("wb_word0_in_mem", backing[32'h40], 32'hA0);
    check_output("wb_word1_in_mem", backing[32'h41], 32'hDEADBEEF);

    // Reset arrives after two refill acks, with the CPU request still held.
    cpu_re = 1'b1; cpu_addr = 32'h0000_2208; #1;
    check_output("mid_miss_stall", 32'(cache_stall), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check_output("mid_refill_req", 32'(mem_req), 32'd1);
      check_output("mid_refill_addr", mem_addr, 32'h0000_2200 + 32'(4 * k));
      mem_ack = 1'b1; mem_rdata = backing[mem_addr[15:2]];
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    rst = 1'b0; #1;
    check_output("async_rst_mem_req", 32'(mem_req), 32'd0);
    check_output("async_rst_stall", 32'(cache_stall), 32'd0);
    check_output("async_rst_mem_addr", mem_addr, 32'd0);
    cpu_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    model_reset();
    apply_stimulus(1'b1, 1'b0, 32'h0000_2208, 32'h0, 0, st, rd);
    check_output("reload_after_rst_stall", 32'(st), 32'd5);
    apply_stimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, st, rd);
    check_output("line_invalid_after_rst", 32'(st), 32'd5);

    tag_pick[0] = 22'd0; tag_pick[1] = 22'd1; tag_pick[2] = 22'd2;
    tag_pick[3] = 22'd3; tag_pick[4] = 22'd16;
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(9, 0));
      a = {tag_pick[$urandom_range(4, 0)], 6'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'b00};
      if (kind == 0)     apply_stimulus(1'b0, 1'b0, a, $urandom, 3, st, rd);
      else if (kind < 5) apply_stimulus(1'b1, 1'b0, a, $urandom, 3, st, rd);
      else if (kind < 8) apply_stimulus(1'b0, 1'b1, a, $urandom, 3, st, rd);
      else               apply_stimulus(1'b1, 1'b1, a, $urandom, 3, st, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
